// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU <-> ROM port: default bus widths and the
// state encoding of the ROM port arbiter.
package cpu_mem_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_grant2.sv
// Two-input round-robin grant. The pointer names the requester preferred on
// a tie; it moves to the other requester whenever a grant is taken.
import cpu_mem_pkg::*;

module rr_grant2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_r;

    // Grant decode: a lone request always wins, a tie goes to the pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer update: after serving m0 prefer m1, after serving m1 prefer m0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_r <= gnt[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single ROM port between instruction fetch (m0) and a
// debug/loader port (m1). One transaction outstanding at a time, round-robin
// grant, and a timeout that answers the requester with zero data if the ROM
// never raises en_out.
import cpu_mem_pkg::*;

module mem_port_arbiter #(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int TO_CYC = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_valid,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_valid,
    output logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_en_out,
    output logic          timeout_err
);

    localparam logic [TIMER_W-1:0] TO_LIM = TIMER_W'(TO_CYC);

    arb_state_t         state_r;
    logic               sel_r;
    logic [TIMER_W-1:0] timer_r;
    logic [1:0]         gnt_s;
    logic               advance_s;

    // Arbiter may only take a new grant while no transaction is in flight.
    always_comb begin
        if (state_r == ST_IDLE) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
    end

    rr_grant2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({m1_req, m0_req}),
        .advance (advance_s),
        .gnt     (gnt_s)
    );

    // Transaction FSM: grant/latch, issue pulse, wait for data or timeout,
    // and steer the response to the granted requester only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sel_r       <= 1'b0;
            timer_r     <= {TIMER_W{1'b0}};
            mem_ready   <= 1'b0;
            mem_addr    <= {AW{1'b0}};
            m0_rdata    <= {DW{1'b0}};
            m1_rdata    <= {DW{1'b0}};
            m0_valid    <= 1'b0;
            m1_valid    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mem_ready   <= 1'b0;
            m0_valid    <= 1'b0;
            m1_valid    <= 1'b0;
            timeout_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_s != 2'b00) begin
                        sel_r     <= gnt_s[1];
                        mem_addr  <= gnt_s[1] ? m1_addr : m0_addr;
                        mem_ready <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    timer_r <= {TIMER_W{1'b0}};
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_en_out) begin
                        // Data wins even if the timer has just expired.
                        if (sel_r) begin
                            m1_rdata <= mem_dout;
                            m1_valid <= 1'b1;
                        end else begin
                            m0_rdata <= mem_dout;
                            m0_valid <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end else if (timer_r == TO_LIM) begin
                        if (sel_r) begin
                            m1_rdata <= {DW{1'b0}};
                            m1_valid <= 1'b1;
                        end else begin
                            m0_rdata <= {DW{1'b0}};
                            m0_valid <= 1'b1;
                        end
                        timeout_err <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single reads, alternating
// round-robin traffic, timeout, spurious/coincident en_out and mid-flight reset.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req;
    logic [15:0] m0_addr;
    logic [15:0] m0_rdata;
    logic        m0_valid;
    logic        m1_req;
    logic [15:0] m1_addr;
    logic [15:0] m1_rdata;
    logic        m1_valid;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_dout;
    logic        mem_en_out;
    logic        timeout_err;

    int checks;
    int errors;

    logic [15:0] exp_rd0;
    logic [15:0] exp_rd1;

    mem_port_arbiter #(.AW(16), .DW(16), .TO_CYC(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req      (m0_req),
        .m0_addr     (m0_addr),
        .m0_rdata    (m0_rdata),
        .m0_valid    (m0_valid),
        .m1_req      (m1_req),
        .m1_addr     (m1_addr),
        .m1_rdata    (m1_rdata),
        .m1_valid    (m1_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .mem_en_out  (mem_en_out),
        .timeout_err (timeout_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit port, input bit v, input logic [15:0] a);
        if (port) begin
            m1_req  = v;
            m1_addr = a;
        end else begin
            m0_req  = v;
            m0_addr = a;
        end
    endtask

    // Single read on one port with the ROM answering the cycle after ready.
    task automatic do_read(input string tag, input bit port, input logic [15:0] a,
                           input logic [15:0] d);
        set_req(port, 1'b1, a);
        step();
        chk({tag, "_ready"}, {31'd0, mem_ready}, 32'd1);
        chk({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, a});
        step();
        mem_en_out = 1'b1;
        mem_dout   = d;
        chk({tag, "_novalid"}, {30'd0, m1_valid, m0_valid}, 32'd0);
        step();
        mem_en_out = 1'b0;
        mem_dout   = 16'h0000;
        if (port) exp_rd1 = d; else exp_rd0 = d;
        chk({tag, "_valid"}, {30'd0, m1_valid, m0_valid}, port ? 32'd2 : 32'd1);
        chk({tag, "_rd0"}, {16'd0, m0_rdata}, {16'd0, exp_rd0});
        chk({tag, "_rd1"}, {16'd0, m1_rdata}, {16'd0, exp_rd1});
        chk({tag, "_noerr"}, {31'd0, timeout_err}, 32'd0);
        set_req(port, 1'b0, a);
        step();
        chk({tag, "_idle"}, {29'd0, mem_ready, m1_valid, m0_valid}, 32'd0);
    endtask

    initial begin
        logic        prev_ready;
        logic [15:0] prev_addr;
        logic        outstanding;
        logic        last_port;
        logic [15:0] last_addr;
        int          issues;
        int          valids;
        int          k;
        bit          done;

        checks     = 0;
        errors     = 0;
        exp_rd0    = 16'h0000;
        exp_rd1    = 16'h0000;
        rst        = 1'b1;
        m0_req     = 1'b1;
        m0_addr    = 16'h0010;
        m1_req     = 1'b1;
        m1_addr    = 16'h0020;
        mem_dout   = 16'h0000;
        mem_en_out = 1'b0;

        // 1: reset held with requests pending
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        end
        chk("rst_valid", {29'd0, timeout_err, m1_valid, m0_valid}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 32'd0);
        rst = 1'b0;
        step();
        chk("rel_ready", {31'd0, mem_ready}, 32'd1);
        chk("rel_addr_m0", {16'd0, mem_addr}, 32'h0010);
        step();
        mem_en_out = 1'b1;
        mem_dout   = 16'hBEEF;
        step();
        mem_en_out = 1'b0;
        chk("rel_valid", {30'd0, m1_valid, m0_valid}, 32'd1);
        chk("rel_rdata", {16'd0, m0_rdata}, 32'h0000BEEF);
        exp_rd0 = 16'hBEEF;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        step();

        // 2: single m0 read
        do_read("m0_single", 1'b0, 16'h0004, 16'h1234);

        // 3: both requesting continuously; pointer favours m1 after two m0 grants
        set_req(1'b0, 1'b1, 16'h0010);
        set_req(1'b1, 1'b1, 16'h0020);
        prev_ready  = 1'b0;
        prev_addr   = 16'h0000;
        outstanding = 1'b0;
        last_port   = 1'b0;
        last_addr   = 16'h0000;
        issues      = 0;
        valids      = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            mem_en_out = prev_ready;
            mem_dout   = prev_ready ? (prev_addr ^ 16'h5A5A) : 16'h0000;
            if (c == 12) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            if (mem_ready) begin
                chk("rr_no_overlap", {31'd0, outstanding}, 32'd0);
                last_port = (issues % 2 == 0);
                last_addr = last_port ? 16'h0020 : 16'h0010;
                chk("rr_issue_addr", {16'd0, mem_addr}, {16'd0, last_addr});
                outstanding = 1'b1;
                issues++;
            end
            if (m0_valid || m1_valid) begin
                chk("rr_valid_port", {30'd0, m1_valid, m0_valid}, last_port ? 32'd2 : 32'd1);
                if (last_port) exp_rd1 = last_addr ^ 16'h5A5A;
                else exp_rd0 = last_addr ^ 16'h5A5A;
                chk("rr_rdata", {m1_rdata, m0_rdata}, {exp_rd1, exp_rd0});
                outstanding = 1'b0;
                valids++;
            end
            prev_ready = mem_ready;
            prev_addr  = mem_addr;
        end
        mem_en_out = 1'b0;
        chk("rr_issue_cnt", issues, 32'd4);
        chk("rr_valid_cnt", valids, 32'd4);
        step();
        chk("rr_quiet", {31'd0, mem_ready}, 32'd0);

        // 4: ROM withheld -> timeout on m1
        set_req(1'b1, 1'b1, 16'h0030);
        step();
        chk("to_ready", {31'd0, mem_ready}, 32'd1);
        chk("to_addr", {16'd0, mem_addr}, 32'h0030);
        k    = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            step();
            k++;
            if (m0_valid || m1_valid || timeout_err) done = 1'b1;
        end
        chk("to_latency", k, 32'd17);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_valid", {30'd0, m1_valid, m0_valid}, 32'd2);
        exp_rd1 = 16'h0000;
        chk("to_rdata", {m1_rdata, m0_rdata}, {exp_rd1, exp_rd0});
        m1_req = 1'b0;
        step();
        chk("to_pulse", {29'd0, timeout_err, m1_valid, m0_valid}, 32'd0);
        do_read("after_to", 1'b0, 16'h0040, 16'h4321);

        // 5a: spurious en_out while idle
        mem_en_out = 1'b1;
        mem_dout   = 16'hFFFF;
        step();
        step();
        chk("spur_none", {28'd0, mem_ready, timeout_err, m1_valid, m0_valid}, 32'd0);
        chk("spur_rdata", {m1_rdata, m0_rdata}, {exp_rd1, exp_rd0});
        mem_en_out = 1'b0;
        mem_dout   = 16'h0000;

        // 5b: en_out in the same cycle the timer hits its limit
        set_req(1'b0, 1'b1, 16'h0050);
        step();
        chk("co_ready", {31'd0, mem_ready}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("co_wait", {29'd0, timeout_err, m1_valid, m0_valid}, 32'd0);
        end
        mem_en_out = 1'b1;
        mem_dout   = 16'hCAFE;
        step();
        mem_en_out = 1'b0;
        mem_dout   = 16'h0000;
        exp_rd0    = 16'hCAFE;
        chk("co_valid", {30'd0, m1_valid, m0_valid}, 32'd1);
        chk("co_rdata", {16'd0, m0_rdata}, {16'd0, exp_rd0});
        chk("co_noerr", {31'd0, timeout_err}, 32'd0);
        m0_req = 1'b0;
        step();

        // 6: reset during WAIT, then a late en_out
        set_req(1'b1, 1'b1, 16'h0060);
        step();
        chk("mr_ready", {31'd0, mem_ready}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst        = 1'b0;
        m1_req     = 1'b0;
        mem_en_out = 1'b1;
        mem_dout   = 16'h7777;
        exp_rd0    = 16'h0000;
        exp_rd1    = 16'h0000;
        chk("mr_cleared", {m1_rdata, m0_rdata}, 32'd0);
        step();
        chk("mr_late1", {29'd0, timeout_err, m1_valid, m0_valid}, 32'd0);
        step();
        chk("mr_late2", {28'd0, mem_ready, timeout_err, m1_valid, m0_valid}, 32'd0);
        mem_en_out = 1'b0;
        mem_dout   = 16'h0000;
        set_req(1'b0, 1'b1, 16'h0070);
        set_req(1'b1, 1'b1, 16'h0080);
        step();
        chk("mr_ptr_m0", {16'd0, mem_addr}, 32'h0070);
        chk("mr_ready2", {31'd0, mem_ready}, 32'd1);
        step();
        mem_en_out = 1'b1;
        mem_dout   = 16'h9999;
        step();
        mem_en_out = 1'b0;
        m0_req     = 1'b0;
        m1_req     = 1'b0;
        chk("mr_valid", {30'd0, m1_valid, m0_valid}, 32'd1);
        chk("mr_rdata", {m1_rdata, m0_rdata}, 32'h00009999);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
